// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side link between the byte FIFO (master) and the UART transmitter (slave).
interface fifo_uart_tx_if;
  logic       fifo_ready;
  logic [7:0] fifo_data;
  logic       fifo_read;

  modport master (output fifo_ready, output fifo_data, input fifo_read);
  modport slave  (input fifo_ready, input fifo_data, output fifo_read);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO: start, 8 data bits LSB-first, optional even parity, stop.
// Outputs are registered from next-state values, so txd/busy/done track the state they describe.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           enable,
  fifo_uart_tx_if.slave  fifo,
  output logic           txd,
  output logic           busy,
  output logic           done
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end, pop;

  assign bit_end = (baud_q == BAUD_LAST);
  assign pop     = ~clr & enable & fifo.fifo_ready &
                   ((state_q == IDLE) | ((state_q == STOP) & bit_end));
  assign fifo.fifo_read = pop;

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (pop) state_d = START;
      end
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
    // Loading here covers both the IDLE pop and the gapless pop on the last stop cycle.
    if (pop) begin
      shreg_d = fifo.fifo_data;
      par_d   = ^fifo.fifo_data;
      bit_d   = 3'd0;
    end

    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      PARITY:  txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
